// File: rtl/e1_pkg.sv
// Shared types and helpers for the e1 ping-pong frame buffer controller.
// Optional statistics outputs are enabled by defining E1_PP_STATS_EN.
package e1_pkg;

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_ACTIVE = 1'b1
    } rd_state_t;

    typedef logic bank_t;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/e1_skid_fifo.sv
// Two-entry valid/ready FIFO holding returned BRAM words ahead of the
// downstream stream; exposes occupancy so the reader can budget credits.
module e1_skid_fifo #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             push_s;
    logic             pop_s;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign in_ready  = (count_r != 2'd2) || out_ready;
    assign out_valid = (count_r != 2'd0);
    assign out_data  = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_r[0] <= {WIDTH{1'b0}};
            mem_r[1] <= {WIDTH{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/e1_pingpong_ctrl.sv
// Ping-pong frame buffer controller: fills two BRAM banks alternately from
// an upstream stream and replays full frames downstream. Define
// E1_PP_STATS_EN to add the frames_out / stall_cycles statistics outputs.
module e1_pingpong_ctrl
    import e1_pkg::*;
#(
    parameter int BRAM_DATA_WIDTH = 64,
    parameter int BRAM_DEPTH      = 64,
    parameter int BRAM_ADDR_WIDTH = clog2(BRAM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [BRAM_DATA_WIDTH-1:0] s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [BRAM_DATA_WIDTH-1:0] m_data,
    output logic                       m_last,
    output logic                       bram0_wr_en,
    output logic                       bram0_we,
    output logic [BRAM_ADDR_WIDTH-1:0] bram0_wr_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram0_din,
    output logic                       bram0_rd_en,
    output logic [BRAM_ADDR_WIDTH-1:0] bram0_rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram0_dout,
    output logic                       bram1_wr_en,
    output logic                       bram1_we,
    output logic [BRAM_ADDR_WIDTH-1:0] bram1_wr_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram1_din,
    output logic                       bram1_rd_en,
    output logic [BRAM_ADDR_WIDTH-1:0] bram1_rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram1_dout
`ifdef E1_PP_STATS_EN
    ,
    output logic [15:0]                frames_out,
    output logic [15:0]                stall_cycles
`endif
);

    localparam int FIFO_W = BRAM_DATA_WIDTH + 1;
    localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR = BRAM_ADDR_WIDTH'(BRAM_DEPTH - 1);
    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ZERO = {BRAM_ADDR_WIDTH{1'b0}};
    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE  = BRAM_ADDR_WIDTH'(1);
    localparam logic [BRAM_DATA_WIDTH-1:0] DATA_ZERO = {BRAM_DATA_WIDTH{1'b0}};

    logic [1:0]                 full_r;
    logic [1:0]                 full_next_s;
    bank_t                      wr_bank_r;
    bank_t                      rd_bank_r;
    bank_t                      rd_bank_q_r;
    logic [BRAM_ADDR_WIDTH-1:0] wr_addr_r;
    logic [BRAM_ADDR_WIDTH-1:0] rd_addr_r;
    rd_state_t                  state_r;
    rd_state_t                  state_next_s;
    logic                       inflight_r;
    logic                       rd_last_q_r;

    logic                       s_ready_s;
    logic                       wr_fire_s;
    logic                       wr_wrap_s;
    logic                       rd_issue_s;
    logic                       rd_done_s;
    logic                       next_bank_full_s;
    logic                       credit_s;
    logic                       pop_s;
    logic [2:0]                 used_s;
    logic [1:0]                 fifo_count_s;
    logic                       fifo_valid_s;
    logic                       fifo_in_ready_s;
    logic [FIFO_W-1:0]          fifo_in_s;
    logic [FIFO_W-1:0]          fifo_out_s;
    logic [BRAM_DATA_WIDTH-1:0] rd_data_s;

    assign s_ready_s = rst_n && !full_r[wr_bank_r];
    assign wr_fire_s = s_valid && s_ready_s;
    assign wr_wrap_s = wr_fire_s && (wr_addr_r == LAST_ADDR);
    assign pop_s     = m_valid && m_ready;

    // A word leaving the FIFO this cycle frees its slot for a new read.
    assign used_s   = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign credit_s = (used_s < 3'd2) && fifo_in_ready_s;

    // The other bank counts as full if its final write lands this cycle.
    assign next_bank_full_s = full_r[~rd_bank_r] || (wr_wrap_s && (wr_bank_r != rd_bank_r));
    assign rd_done_s        = rd_issue_s && (rd_addr_r == LAST_ADDR);

    // Read FSM: the first read is issued in the cycle a full bank is seen.
    always_comb begin
        state_next_s = state_r;
        rd_issue_s   = 1'b0;
        case (state_r)
            RD_IDLE: begin
                if (rst_n && full_r[rd_bank_r]) begin
                    rd_issue_s   = credit_s;
                    state_next_s = RD_ACTIVE;
                end else begin
                    state_next_s = RD_IDLE;
                end
            end
            RD_ACTIVE: begin
                rd_issue_s = rst_n && credit_s;
                if (rd_issue_s && (rd_addr_r == LAST_ADDR)) begin
                    state_next_s = next_bank_full_s ? RD_ACTIVE : RD_IDLE;
                end else begin
                    state_next_s = RD_ACTIVE;
                end
            end
            default: begin
                state_next_s = RD_IDLE;
                rd_issue_s   = 1'b0;
            end
        endcase
    end

    // Full flags: set by the writer and cleared by the reader independently.
    always_comb begin
        full_next_s = full_r;
        if (wr_wrap_s) begin
            full_next_s[wr_bank_r] = 1'b1;
        end else begin
            full_next_s[wr_bank_r] = full_r[wr_bank_r];
        end
        if (rd_done_s) begin
            full_next_s[rd_bank_r] = 1'b0;
        end else begin
            full_next_s[rd_bank_r] = full_next_s[rd_bank_r];
        end
    end

    // Bank pointers, address counters, FSM state and read pipeline tags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_r      <= 2'b00;
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b0;
            wr_addr_r   <= ADDR_ZERO;
            rd_addr_r   <= ADDR_ZERO;
            state_r     <= RD_IDLE;
            inflight_r  <= 1'b0;
            rd_bank_q_r <= 1'b0;
            rd_last_q_r <= 1'b0;
        end else begin
            full_r  <= full_next_s;
            state_r <= state_next_s;
            if (wr_fire_s) begin
                wr_addr_r <= wr_wrap_s ? ADDR_ZERO : (wr_addr_r + ADDR_ONE);
                wr_bank_r <= wr_wrap_s ? ~wr_bank_r : wr_bank_r;
            end
            if (rd_issue_s) begin
                rd_addr_r <= rd_done_s ? ADDR_ZERO : (rd_addr_r + ADDR_ONE);
                rd_bank_r <= rd_done_s ? ~rd_bank_r : rd_bank_r;
            end
            inflight_r  <= rd_issue_s;
            rd_bank_q_r <= rd_bank_r;
            rd_last_q_r <= rd_done_s;
        end
    end

    assign rd_data_s = rd_bank_q_r ? bram1_dout : bram0_dout;
    assign fifo_in_s = {rd_last_q_r, rd_data_s};

    e1_skid_fifo #(
        .WIDTH(FIFO_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inflight_r),
        .in_ready (fifo_in_ready_s),
        .in_data  (fifo_in_s),
        .out_valid(fifo_valid_s),
        .out_ready(m_ready && rst_n),
        .out_data (fifo_out_s),
        .count    (fifo_count_s)
    );

    // Outputs are forced to their idle values while rst_n is held low.
    assign s_ready = s_ready_s;
    assign m_valid = rst_n && fifo_valid_s;
    assign m_data  = rst_n ? fifo_out_s[BRAM_DATA_WIDTH-1:0] : DATA_ZERO;
    assign m_last  = m_valid && fifo_out_s[BRAM_DATA_WIDTH];

    assign bram0_wr_en   = wr_fire_s && (wr_bank_r == 1'b0);
    assign bram0_we      = bram0_wr_en;
    assign bram0_wr_addr = rst_n ? wr_addr_r : ADDR_ZERO;
    assign bram0_din     = rst_n ? s_data : DATA_ZERO;
    assign bram0_rd_en   = rd_issue_s && (rd_bank_r == 1'b0);
    assign bram0_rd_addr = rst_n ? rd_addr_r : ADDR_ZERO;

    assign bram1_wr_en   = wr_fire_s && (wr_bank_r == 1'b1);
    assign bram1_we      = bram1_wr_en;
    assign bram1_wr_addr = rst_n ? wr_addr_r : ADDR_ZERO;
    assign bram1_din     = rst_n ? s_data : DATA_ZERO;
    assign bram1_rd_en   = rd_issue_s && (rd_bank_r == 1'b1);
    assign bram1_rd_addr = rst_n ? rd_addr_r : ADDR_ZERO;

`ifdef E1_PP_STATS_EN
    logic [15:0] frames_r;
    logic [15:0] stall_r;

    // Frame counter wraps; stall counter saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_r <= 16'd0;
            stall_r  <= 16'd0;
        end else begin
            if (pop_s && m_last) begin
                frames_r <= frames_r + 16'd1;
            end
            if (s_valid && !s_ready_s && (stall_r != 16'hFFFF)) begin
                stall_r <= stall_r + 16'd1;
            end
        end
    end

    assign frames_out   = frames_r;
    assign stall_cycles = stall_r;
`endif

endmodule

// File: tb/tb_e1_pingpong_ctrl.sv
// Scoreboard bench for e1_pingpong_ctrl with a 1-cycle-latency BRAM model.
// Statistics checks are compiled in when E1_PP_STATS_EN is defined.
module tb_e1_pingpong_ctrl;

    localparam int W  = 64;
    localparam int D  = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          bram0_wr_en, bram0_we, bram0_rd_en;
    logic [AW-1:0] bram0_wr_addr, bram0_rd_addr;
    logic [W-1:0]  bram0_din, bram0_dout;
    logic          bram1_wr_en, bram1_we, bram1_rd_en;
    logic [AW-1:0] bram1_wr_addr, bram1_rd_addr;
    logic [W-1:0]  bram1_din, bram1_dout;
`ifdef E1_PP_STATS_EN
    logic [15:0]   frames_out;
    logic [15:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    e1_pingpong_ctrl #(
        .BRAM_DATA_WIDTH(W),
        .BRAM_DEPTH     (D),
        .BRAM_ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .bram0_wr_en  (bram0_wr_en),
        .bram0_we     (bram0_we),
        .bram0_wr_addr(bram0_wr_addr),
        .bram0_din    (bram0_din),
        .bram0_rd_en  (bram0_rd_en),
        .bram0_rd_addr(bram0_rd_addr),
        .bram0_dout   (bram0_dout),
        .bram1_wr_en  (bram1_wr_en),
        .bram1_we     (bram1_we),
        .bram1_wr_addr(bram1_wr_addr),
        .bram1_din    (bram1_din),
        .bram1_rd_en  (bram1_rd_en),
        .bram1_rd_addr(bram1_rd_addr),
        .bram1_dout   (bram1_dout)
`ifdef E1_PP_STATS_EN
        ,
        .frames_out   (frames_out),
        .stall_cycles (stall_cycles)
`endif
    );

    // Two independent banks with one cycle of read latency.
    logic [W-1:0] mem0 [D];
    logic [W-1:0] mem1 [D];
    always @(posedge clk) begin
        if (bram0_wr_en && bram0_we) mem0[bram0_wr_addr] <= bram0_din;
        if (bram1_wr_en && bram1_we) mem1[bram1_wr_addr] <= bram1_din;
        if (bram0_rd_en) bram0_dout <= mem0[bram0_rd_addr];
        if (bram1_rd_en) bram1_dout <= mem1[bram1_rd_addr];
    end

    int          vectors = 0;
    int          miscompares = 0;
    longint      cyc = 0;
    logic [W:0]  exp_q [$];
    logic [W:0]  exp_e;
    int          wr_idx = 0;
    bit          lat_arm = 1'b0;
    longint      last_wr_cyc = 0;
    bit          prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    bit          exp_bank;
    int          frames_model = 0;
    int          stall_model = 0;
    int          stalls;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard push on write handshake, pop/compare on read handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            wr_idx       = 0;
            prev_stall   = 1'b0;
            frames_model = 0;
            stall_model  = 0;
        end else begin
            check_val("wr_excl", {63'd0, bram0_wr_en & bram1_wr_en}, 64'd0);
            check_val("rd_excl", {63'd0, bram0_rd_en & bram1_rd_en}, 64'd0);
            if (s_valid && !s_ready && stall_model < 65535) stall_model++;
            if (s_valid && s_ready) begin
                exp_bank = ((wr_idx / D) % 2) == 1;
                check_val("wr_strobe", {60'd0, bram1_wr_en, bram1_we, bram0_wr_en, bram0_we},
                          exp_bank ? 64'd12 : 64'd3);
                check_val("wr_addr", {58'd0, exp_bank ? bram1_wr_addr : bram0_wr_addr}, 64'(wr_idx % D));
                check_val("wr_din", exp_bank ? bram1_din : bram0_din, s_data);
                exp_q.push_back({((wr_idx % D) == D - 1), s_data});
                if ((wr_idx % D) == D - 1) last_wr_cyc = cyc;
                wr_idx++;
            end
            if (prev_stall) begin
                check_val("hold_valid", {63'd0, m_valid}, 64'd1);
                check_val("hold_data", m_data, prev_data);
            end
            if (m_valid && lat_arm) begin
                check_val("latency", 64'(cyc - last_wr_cyc), 64'd3);
                lat_arm = 1'b0;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_word", m_data, 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_val("m_data", m_data, exp_e[W-1:0]);
                    check_val("m_last", {63'd0, m_last}, {63'd0, exp_e[W]});
                    if (exp_e[W]) frames_model++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic drive_beats(input int n, input logic [63:0] base, output int nstall);
        int guard;
        nstall = 0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + 64'(i);
            guard   = 0;
            @(negedge clk);
            while (!s_ready && guard < 2000) begin
                guard++;
                nstall++;
                @(negedge clk);
            end
            if (guard >= 2000) begin
                check_val("s_ready_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic toggle_ready(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            m_ready = ~m_ready;
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || m_valid) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_val("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_s_ready", {63'd0, s_ready}, 64'd0);
        check_val("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check_val("rst_m_last", {63'd0, m_last}, 64'd0);
        check_val("rst_strobes", {58'd0, bram0_wr_en, bram0_we, bram0_rd_en,
                                  bram1_wr_en, bram1_we, bram1_rd_en}, 64'd0);
        check_val("rst_addrs", {40'd0, bram0_wr_addr, bram0_rd_addr, bram1_wr_addr, bram1_rd_addr}, 64'd0);
        check_val("rst_din", bram0_din | bram1_din, 64'd0);
`ifdef E1_PP_STATS_EN
        check_val("rst_stats", {32'd0, frames_out, stall_cycles}, 64'd0);
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 64'h5A5A_5A5A_5A5A_5A5A;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        s_valid = 1'b0;
        rst_n   = 1'b1;
        #1;
        check_val("s_ready_after_rst", {63'd0, s_ready}, 64'd1);

        // One frame 0..63 with the consumer always ready.
        m_ready = 1'b1;
        lat_arm = 1'b1;
        drive_beats(64, 64'd0, stalls);
        check_val("t1_stalls", 64'(stalls), 64'd0);
        wait_drain();
        check_val("t1_latency_seen", {63'd0, lat_arm}, 64'd0);

        // Two frames with the consumer blocked, then five refused beats.
        m_ready = 1'b0;
        drive_beats(128, 64'd100, stalls);
        check_val("t2_stalls", 64'(stalls), 64'd0);
        s_valid = 1'b1;
        s_data  = 64'hFFFF;
        repeat (5) begin
            @(negedge clk);
            check_val("t2_s_ready_full", {63'd0, s_ready}, 64'd0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_drain();
`ifdef E1_PP_STATS_EN
        check_val("frames_out", {48'd0, frames_out}, 64'd3);
        check_val("stall_cycles", {48'd0, stall_cycles}, 64'd5);
        check_val("stall_model", {48'd0, stall_cycles}, 64'(stall_model));
`endif

        // Consumer toggling every cycle during a frame.
        m_ready = 1'b0;
        fork
            drive_beats(64, 64'd500, stalls);
            toggle_ready(300);
        join
        m_ready = 1'b1;
        wait_drain();

        // Three back-to-back frames: last write to bank1 meets last read of bank0.
        drive_beats(192, 64'd1000, stalls);
        check_val("t4_stalls", 64'(stalls), 64'd0);
        wait_drain();

        // Reset in the middle of a frame discards it.
        drive_beats(30, 64'd2000, stalls);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        s_valid = 1'b0;
        rst_n   = 1'b1;
        #1;
        check_val("s_ready_after_rst2", {63'd0, s_ready}, 64'd1);
        drive_beats(64, 64'd3000, stalls);
        wait_drain();
`ifdef E1_PP_STATS_EN
        check_val("frames_after_rst", {48'd0, frames_out}, 64'(frames_model));
`endif
        check_val("frames_after_rst_model", 64'(frames_model), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
